// File: rtl/si_cmd_decoder.sv
// si_cmd_decoder: assembles host bytes from the FT245 receive simple interface
// into register write frames (address, data MSB, data LSB) and presents each
// completed frame as a single ready/ack write to the configuration register bank.
// Partial frames are dropped after an inter-byte timeout.
// Optional feature macro: SI_CMD_CHECKSUM_EN adds a 4th XOR checksum byte.
module si_cmd_decoder #(
  parameter int SI_WIDTH       = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 2 * SI_WIDTH,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SI_WIDTH-1:0]   rx_data_si,
  input  logic                  rx_rdy_si,
  output logic                  rx_ack_si,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic                  reg_wr_rdy,
  input  logic                  reg_wr_ack,
  output logic                  frame_err
);

  // The timer only needs to count to TIMEOUT_CYCLES-1; the expiry fires on
  // the edge that would have taken it to TIMEOUT_CYCLES.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_ADDR   = 3'd0,
    ST_DATA_H = 3'd1,
    ST_DATA_L = 3'd2,
`ifdef SI_CMD_CHECKSUM_EN
    ST_CHK    = 3'd3,
`endif
    ST_WRITE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          accept;
  logic          expire;
  logic          chk_bad;
  logic          wr_set;
  logic          wr_clr;
  logic          ld_addr;
  logic          ld_hi;
  logic          ld_lo;
  logic          timed;

`ifdef SI_CMD_CHECKSUM_EN
  // Raw address byte kept whole so the checksum covers all 8 bits even if
  // ADDR_WIDTH is narrower than the byte.
  logic [SI_WIDTH-1:0] addr_byte;
`endif

  // Next-state, byte acceptance and inter-byte timeout decisions.
  always_comb begin
    state_next = state;
    timer_next = '0;
    accept     = 1'b0;
    expire     = 1'b0;
    chk_bad    = 1'b0;
    wr_set     = 1'b0;
    wr_clr     = 1'b0;
    ld_addr    = 1'b0;
    ld_hi      = 1'b0;
    ld_lo      = 1'b0;
    timed      = 1'b0;
    case (state)
      ST_ADDR: begin
        if (rx_rdy_si && !rx_ack_si) begin
          accept     = 1'b1;
          ld_addr    = 1'b1;
          state_next = ST_DATA_H;
        end
      end
      ST_DATA_H: begin
        timed = 1'b1;
        if (rx_rdy_si && !rx_ack_si) begin
          accept     = 1'b1;
          ld_hi      = 1'b1;
          state_next = ST_DATA_L;
        end
      end
      ST_DATA_L: begin
        timed = 1'b1;
        if (rx_rdy_si && !rx_ack_si) begin
          accept = 1'b1;
          ld_lo  = 1'b1;
`ifdef SI_CMD_CHECKSUM_EN
          state_next = ST_CHK;
`else
          wr_set     = 1'b1;
          state_next = ST_WRITE;
`endif
        end
      end
`ifdef SI_CMD_CHECKSUM_EN
      ST_CHK: begin
        timed = 1'b1;
        if (rx_rdy_si && !rx_ack_si) begin
          accept = 1'b1;
          if (rx_data_si == (addr_byte ^ reg_data[DATA_WIDTH-1:SI_WIDTH] ^ reg_data[SI_WIDTH-1:0])) begin
            wr_set     = 1'b1;
            state_next = ST_WRITE;
          end else begin
            chk_bad    = 1'b1;
            state_next = ST_ADDR;
          end
        end
      end
`endif
      ST_WRITE: begin
        if (reg_wr_ack) begin
          wr_clr     = 1'b1;
          state_next = ST_ADDR;
        end
      end
      default: state_next = ST_ADDR;
    endcase
    if (timed && !accept && (TIMEOUT_CYCLES != 0)) begin
      if (timer == TIMER_LAST) begin
        expire     = 1'b1;
        state_next = ST_ADDR;
      end else begin
        timer_next = timer + 1'b1;
      end
    end
  end

  // State, timer, handshake outputs and captured frame fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ADDR;
      timer      <= '0;
      rx_ack_si  <= 1'b0;
      reg_wr_rdy <= 1'b0;
      frame_err  <= 1'b0;
      reg_addr   <= '0;
      reg_data   <= '0;
`ifdef SI_CMD_CHECKSUM_EN
      addr_byte  <= '0;
`endif
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      rx_ack_si <= accept;
      frame_err <= expire | chk_bad;
      if (wr_set) begin
        reg_wr_rdy <= 1'b1;
      end else if (wr_clr) begin
        reg_wr_rdy <= 1'b0;
      end
      if (ld_addr) begin
        reg_addr <= rx_data_si[ADDR_WIDTH-1:0];
`ifdef SI_CMD_CHECKSUM_EN
        addr_byte <= rx_data_si;
`endif
      end
      if (ld_hi) begin
        reg_data[DATA_WIDTH-1:SI_WIDTH] <= rx_data_si;
      end
      if (ld_lo) begin
        reg_data[SI_WIDTH-1:0] <= rx_data_si;
      end
    end
  end

endmodule

// File: tb/tb_si_cmd_decoder.sv
// tb_si_cmd_decoder: directed and randomized frames against a frame-level
// reference model (expected write = address byte and {MSB, LSB}; checksum is
// the XOR of the three raw bytes; a partial frame idle for 100 edges drops).
module tb_si_cmd_decoder;

  localparam int TO = 100;
`ifdef SI_CMD_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data_si = 8'h00;
  logic        rx_rdy_si = 1'b0;
  logic        rx_ack_si;
  logic [7:0]  reg_addr;
  logic [15:0] reg_data;
  logic        reg_wr_rdy;
  logic        reg_wr_ack = 1'b0;
  logic        frame_err;

  si_cmd_decoder #(
    .SI_WIDTH(8),
    .ADDR_WIDTH(8),
    .DATA_WIDTH(16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data_si(rx_data_si),
    .rx_rdy_si(rx_rdy_si),
    .rx_ack_si(rx_ack_si),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .reg_wr_rdy(reg_wr_rdy),
    .reg_wr_ack(reg_wr_ack),
    .frame_err(frame_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_errs = 0;

  // Protocol monitor: counts error pulses and handshake rule breaks.
  int   ack_b2b    = 0;
  int   ack_in_wr  = 0;
  int   err_pulses = 0;
  int   err_b2b    = 0;
  logic prev_ack   = 1'b0;
  logic prev_wr    = 1'b0;
  logic prev_err   = 1'b0;

  always @(negedge clk) begin
    if (rx_ack_si === 1'b1 && prev_ack === 1'b1) ack_b2b++;
    if (rx_ack_si === 1'b1 && prev_wr === 1'b1) ack_in_wr++;
    if (frame_err === 1'b1) err_pulses++;
    if (frame_err === 1'b1 && prev_err === 1'b1) err_b2b++;
    prev_ack = rx_ack_si;
    prev_wr  = reg_wr_rdy;
    prev_err = frame_err;
  end

  // Watchdog so the run always ends.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one byte (called at a negedge) and hold it until acknowledged.
  task automatic applyStimulus(input logic [7:0] b);
    bit got;
    got = 1'b0;
    rx_data_si = b;
    rx_rdy_si  = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (rx_ack_si === 1'b1) got = 1'b1;
    end
    rx_rdy_si = 1'b0;
    checkOutput("byte_acked", {31'd0, got}, 32'd1);
  endtask

  // Send a full frame; corrupt selects a wrong checksum byte.
  task automatic sendFrame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                           input bit corrupt, input int gap_max);
    logic [7:0] bytes [4];
    bytes[0] = a;
    bytes[1] = h;
    bytes[2] = l;
    bytes[3] = a ^ h ^ l;
    if (corrupt) bytes[3] = bytes[3] ^ 8'($urandom_range(1, 255));
    for (int i = 0; i < FLEN; i++) begin
      if (i > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      applyStimulus(bytes[i]);
    end
    if (corrupt) begin
      checkOutput("chk_err", {31'd0, frame_err}, 32'd1);
      checkOutput("chk_nowr", {31'd0, reg_wr_rdy}, 32'd0);
      exp_errs++;
      @(negedge clk);
      checkOutput("chk_err_pulse", {31'd0, frame_err}, 32'd0);
      checkOutput("chk_nowr2", {31'd0, reg_wr_rdy}, 32'd0);
    end else begin
      checkOutput("wr_rdy_same_edge", {31'd0, reg_wr_rdy}, 32'd1);
      checkOutput("no_err", {31'd0, frame_err}, 32'd0);
    end
  endtask

  // Hold the pending write for some cycles, then acknowledge it.
  task automatic doWrite(input logic [7:0] ea, input logic [15:0] ed, input int hold);
    for (int i = 0; i < 50 && reg_wr_rdy !== 1'b1; i++) @(negedge clk);
    checkOutput("wr_rdy_up", {31'd0, reg_wr_rdy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      checkOutput("wr_hold", {31'd0, reg_wr_rdy}, 32'd1);
      @(negedge clk);
    end
    checkOutput("wr_addr", {24'd0, reg_addr}, {24'd0, ea});
    checkOutput("wr_data", {16'd0, reg_data}, {16'd0, ed});
    reg_wr_ack = 1'b1;
    @(negedge clk);
    reg_wr_ack = 1'b0;
    checkOutput("wr_done", {31'd0, reg_wr_rdy}, 32'd0);
  endtask

  // Leave a partial frame idle and expect a drop exactly at the limit.
  task automatic partialTimeout(input int nbytes);
    for (int i = 0; i < nbytes; i++) applyStimulus(8'($urandom));
    repeat (TO - 1) @(negedge clk);
    checkOutput("to_early", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    checkOutput("to_err", {31'd0, frame_err}, 32'd1);
    checkOutput("to_nowr", {31'd0, reg_wr_rdy}, 32'd0);
    exp_errs++;
    @(negedge clk);
    checkOutput("to_pulse", {31'd0, frame_err}, 32'd0);
  endtask

  // Directed sequence followed by randomized frames.
  initial begin
    logic [7:0] a, h, l;
    int kind;

    // Reset held with a byte waiting: nothing is acknowledged.
    rx_rdy_si  = 1'b1;
    rx_data_si = 8'h55;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_ack", {31'd0, rx_ack_si}, 32'd0);
      checkOutput("rst_wr", {31'd0, reg_wr_rdy}, 32'd0);
      checkOutput("rst_err", {31'd0, frame_err}, 32'd0);
      checkOutput("rst_addr", {24'd0, reg_addr}, 32'd0);
      checkOutput("rst_data", {16'd0, reg_data}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ack", {31'd0, rx_ack_si}, 32'd1);
    checkOutput("post_rst_addr", {24'd0, reg_addr}, 32'h55);
    rx_rdy_si = 1'b0;
    applyStimulus(8'h66);
    applyStimulus(8'h77);
`ifdef SI_CMD_CHECKSUM_EN
    applyStimulus(8'h44);
`endif
    doWrite(8'h55, 16'h6677, 2);

    // Reference frame.
    sendFrame(8'h12, 8'hAB, 8'hCD, 1'b0, 0);
    doWrite(8'h12, 16'hABCD, 5);

    // Backpressure: next address byte waits while the write is withheld.
    sendFrame(8'h01, 8'h02, 8'h03, 1'b0, 1);
    rx_data_si = 8'h34;
    rx_rdy_si  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_no_ack", {31'd0, rx_ack_si}, 32'd0);
    end
    checkOutput("bp_addr", {24'd0, reg_addr}, 32'h01);
    reg_wr_ack = 1'b1;
    @(negedge clk);
    reg_wr_ack = 1'b0;
    checkOutput("bp_wr_done", {31'd0, reg_wr_rdy}, 32'd0);
    checkOutput("bp_ack_wait", {31'd0, rx_ack_si}, 32'd0);
    @(negedge clk);
    checkOutput("bp_ack_next", {31'd0, rx_ack_si}, 32'd1);
    checkOutput("bp_new_addr", {24'd0, reg_addr}, 32'h34);
    rx_rdy_si = 1'b0;
    applyStimulus(8'h56);
    applyStimulus(8'h78);
`ifdef SI_CMD_CHECKSUM_EN
    applyStimulus(8'h1A);
`endif
    doWrite(8'h34, 16'h5678, 1);

    // Timeout after two bytes, then a clean frame.
    applyStimulus(8'h05);
    applyStimulus(8'h11);
    repeat (TO - 1) @(negedge clk);
    checkOutput("to99_no_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    checkOutput("to100_err", {31'd0, frame_err}, 32'd1);
    checkOutput("to100_nowr", {31'd0, reg_wr_rdy}, 32'd0);
    checkOutput("to_stale_addr", {24'd0, reg_addr}, 32'h05);
    exp_errs++;
    @(negedge clk);
    checkOutput("to_single", {31'd0, frame_err}, 32'd0);
    sendFrame(8'h07, 8'h00, 8'h01, 1'b0, 2);
    doWrite(8'h07, 16'h0001, 0);

    // Byte accepted on the very edge the limit would expire: no drop.
    applyStimulus(8'h09);
    repeat (TO - 1) @(negedge clk);
    applyStimulus(8'h0E);
    checkOutput("edge_no_err", {31'd0, frame_err}, 32'd0);
    applyStimulus(8'h0F);
`ifdef SI_CMD_CHECKSUM_EN
    applyStimulus(8'h09 ^ 8'h0E ^ 8'h0F);
`endif
    doWrite(8'h09, 16'h0E0F, 1);

`ifdef SI_CMD_CHECKSUM_EN
    // Bad checksum on the reference frame.
    rx_data_si = 8'h12;
    applyStimulus(8'h12);
    applyStimulus(8'hAB);
    applyStimulus(8'hCD);
    applyStimulus(8'h75);
    checkOutput("bad_chk_err", {31'd0, frame_err}, 32'd1);
    checkOutput("bad_chk_nowr", {31'd0, reg_wr_rdy}, 32'd0);
    exp_errs++;
    @(negedge clk);
`endif

    // Reset in the middle of a pending write.
    sendFrame(8'h21, 8'h43, 8'h65, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstw_wr", {31'd0, reg_wr_rdy}, 32'd0);
    checkOutput("rstw_addr", {24'd0, reg_addr}, 32'd0);
    checkOutput("rstw_data", {16'd0, reg_data}, 32'd0);
    checkOutput("rstw_err", {31'd0, frame_err}, 32'd0);
    sendFrame(8'h0A, 8'hBC, 8'hDE, 1'b0, 1);
    doWrite(8'h0A, 16'hBCDE, 2);

    // Randomized frames, drops and checksum errors.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      a = 8'($urandom);
      h = 8'($urandom);
      l = 8'($urandom);
      if (kind < 2) begin
        partialTimeout($urandom_range(1, FLEN - 1));
`ifdef SI_CMD_CHECKSUM_EN
      end else if (kind == 2) begin
        sendFrame(a, h, l, 1'b1, 3);
`endif
      end else begin
        sendFrame(a, h, l, 1'b0, 3);
        doWrite(a, {h, l}, $urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    checkOutput("ack_back_to_back", ack_b2b, 32'd0);
    checkOutput("ack_during_write", ack_in_wr, 32'd0);
    checkOutput("err_back_to_back", err_b2b, 32'd0);
    checkOutput("err_pulse_count", err_pulses, exp_errs);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
